// File: rtl/benes_pipe.sv
// rtl/benes_pipe.sv - pipelined Benes permutation network with double-buffered switch configuration
//
// Routes N = 2^LOG_N lanes of DATA_W-bit words through S = 2*LOG_N-1 registered
// stages of 2x2 switches. Each switch has its own control bit. The control bits
// for a beat are captured when the beat is accepted and travel down the pipe
// with it, so loading a new configuration never disturbs beats already in flight.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   in_valid/in_ready      input beat handshake (in_ready is combinational)
//   in_data, in_last       N lanes packed lane k at [k*DATA_W +: DATA_W]; frame end marker
//   out_valid/out_ready    output beat handshake
//   out_data, out_last     permuted lanes (same packing); in_last delayed with its beat
//   cfg_valid/cfg_ready    configuration handshake into the shadow register
//   cfg_bits               bit k*N/2+j controls switch j of stage k (stage 0 input-side)

module benes_pipe #(
    parameter int DATA_W = 32,
    parameter int LOG_N  = 4,
    localparam int N     = 1 << LOG_N,
    localparam int S     = 2 * LOG_N - 1,
    localparam int CFG_W = S * N / 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*DATA_W-1:0] out_data,
    output logic                out_last,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_bits
);

    localparam int HALF   = N / 2;
    localparam int MID    = LOG_N - 1;
    localparam int NW     = N * DATA_W;
    // Register p (0 = input register) keeps control bits for stages p..S-1 only,
    // so the config pipe is triangular: HALF * (S + (S-1) + ... + 1) bits.
    localparam int PIPE_W = HALF * S * (S + 1) / 2;

    // Offset of register p's slice within the triangular config pipe.
    function automatic int cfg_off(input int p);
        int acc;
        acc = 0;
        for (int q = 0; q < p; q++) begin
            acc += S - q;
        end
        return acc * HALF;
    endfunction

    // Output-side stages: switch i of a size-M block takes upper lane o+i and
    // lower lane o+M/2+i. Returns the lane feeding switch-local position p.
    function automatic int pre_src(input int k, input int p);
        int m, o, q;
        if (k <= MID) begin
            return p;
        end
        m = 1 << (k - MID + 1);
        o = p - (p % m);
        q = p % m;
        if ((q % 2) == 0) begin
            return o + q / 2;
        end
        return o + m / 2 + q / 2;
    endfunction

    // Input-side stages: upper switch output of pair i goes to lane o+i,
    // lower output to lane o+M/2+i. Returns the switch output feeding lane p.
    function automatic int post_src(input int k, input int p);
        int m, o, q;
        if (k >= MID) begin
            return p;
        end
        m = N >> k;
        o = p - (p % m);
        q = p % m;
        if (q < m / 2) begin
            return o + 2 * q;
        end
        return o + 2 * (q - m / 2) + 1;
    endfunction

    typedef enum logic {
        BOUNDARY = 1'b0,
        IN_FRAME = 1'b1
    } frame_t;

    frame_t             state, state_nxt;
    logic [CFG_W-1:0]   active_cfg, shadow_cfg, eff_cfg;
    logic               pending;
    logic               promote, cfg_fire, accept, stall;

    // dp[0] is the input register, dp[k+1] holds the output of switch stage k.
    logic [NW-1:0]      dp [0:S];
    logic [NW-1:0]      dn [0:S];
    logic [S:0]         vp, vn, lp, ln;
    logic [PIPE_W-1:0]  cfg_pipe, cfg_nxt;

    assign stall     = vp[S] && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign cfg_ready = !pending;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign promote   = pending && (state == BOUNDARY);
    // A beat accepted on the promotion edge already belongs to the new frame.
    assign eff_cfg   = promote ? shadow_cfg : active_cfg;

    assign out_valid = vp[S];
    assign out_last  = lp[S];
    assign out_data  = dp[S];

    always_comb begin
        state_nxt = state;
        case (state)
            BOUNDARY: if (accept && !in_last) state_nxt = IN_FRAME;
            IN_FRAME: if (accept && in_last)  state_nxt = BOUNDARY;
            default:  state_nxt = BOUNDARY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOUNDARY;
            active_cfg <= '0;
            shadow_cfg <= '0;
            pending    <= 1'b0;
        end else begin
            state <= state_nxt;
            // promote needs pending=1 and cfg_fire needs pending=0: never both.
            if (promote) begin
                active_cfg <= shadow_cfg;
                pending    <= 1'b0;
            end else if (cfg_fire) begin
                shadow_cfg <= cfg_bits;
                pending    <= 1'b1;
            end
        end
    end

    assign dn[0]                 = in_data;
    assign vn                    = {vp[S-1:0], accept};
    assign ln                    = {lp[S-1:0], in_last};
    assign cfg_nxt[0 +: CFG_W]   = eff_cfg;

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int OFF = cfg_off(k);
        logic [NW-1:0] pre, sw, post;

        for (genvar p = 0; p < N; p++) begin : g_pre
            localparam int SRC = pre_src(k, p);
            assign pre[p*DATA_W +: DATA_W] = dp[k][SRC*DATA_W +: DATA_W];
        end

        for (genvar j = 0; j < HALF; j++) begin : g_sw
            logic ctl;
            assign ctl = cfg_pipe[OFF+j];
            assign sw[(2*j)*DATA_W +: DATA_W]   = ctl ? pre[(2*j+1)*DATA_W +: DATA_W]
                                                      : pre[(2*j)*DATA_W +: DATA_W];
            assign sw[(2*j+1)*DATA_W +: DATA_W] = ctl ? pre[(2*j)*DATA_W +: DATA_W]
                                                      : pre[(2*j+1)*DATA_W +: DATA_W];
        end

        for (genvar p = 0; p < N; p++) begin : g_post
            localparam int SRC = post_src(k, p);
            assign post[p*DATA_W +: DATA_W] = sw[SRC*DATA_W +: DATA_W];
        end

        assign dn[k+1] = post;

        // Drop this stage's own control bits and pass the rest along.
        if (k < S - 1) begin : g_cfg
            localparam int REM = (S - 1 - k) * HALF;
            assign cfg_nxt[cfg_off(k+1) +: REM] = cfg_pipe[OFF+HALF +: REM];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= S; k++) begin
                dp[k] <= '0;
            end
            vp       <= '0;
            lp       <= '0;
            cfg_pipe <= '0;
        end else if (!stall) begin
            for (int k = 0; k <= S; k++) begin
                dp[k] <= dn[k];
            end
            vp       <= vn;
            lp       <= ln;
            cfg_pipe <= cfg_nxt;
        end
    end

endmodule

// File: tb/tb_benes_pipe.sv
// tb/tb_benes_pipe.sv - scoreboard testbench for benes_pipe

module tb_benes_pipe;

    localparam int DATA_W = 32;
    localparam int LOG_N  = 4;
    localparam int N      = 16;
    localparam int S      = 7;
    localparam int CFG_W  = 56;
    localparam int NW     = N * DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, in_last;
    logic [NW-1:0]     in_data;
    logic              out_valid, out_ready, out_last;
    logic [NW-1:0]     out_data;
    logic              cfg_valid, cfg_ready;
    logic [CFG_W-1:0]  cfg_bits;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NW-1:0] data;
        logic          last;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t sb[$];

    benes_pipe #(.DATA_W(DATA_W), .LOG_N(LOG_N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_bits (cfg_bits)
    );

    function automatic logic [NW-1:0] lanes(input int tag);
        logic [NW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DATA_W +: DATA_W] = (k << 16) | tag;
        return v;
    endfunction

    function automatic logic [NW-1:0] swap2(input logic [NW-1:0] v, input int a, input int b);
        logic [NW-1:0] r;
        r = v;
        r[a*DATA_W +: DATA_W] = v[b*DATA_W +: DATA_W];
        r[b*DATA_W +: DATA_W] = v[a*DATA_W +: DATA_W];
        return r;
    endfunction

    function automatic logic [NW-1:0] pairs(input logic [NW-1:0] v);
        logic [NW-1:0] r;
        r = v;
        for (int i = 0; i < N / 2; i++) r = swap2(r, 2 * i, 2 * i + 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [NW-1:0] got, input logic [NW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: pops on every output transfer, checks stall behaviour.
    exp_t          e;
    logic [NW-1:0] prev_data;
    bit            prev_stall = 0;

    always @(negedge clk) begin
        if (!rst && out_valid && !out_ready) begin
            check("in_ready_stall", {511'b0, in_ready}, '0);
            if (prev_stall) check("out_data_stable", out_data, prev_data);
            prev_stall = 1;
            prev_data  = out_data;
        end else begin
            prev_stall = 0;
        end
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none", out_data);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_last", {511'b0, out_last}, {511'b0, e.last});
                if (e.lat) check("latency", NW'(cyc - e.acc), NW'(S));
            end
        end
    end

    task automatic send(input logic [NW-1:0] d, input logic last, input logic [NW-1:0] want, input bit lat);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc = 0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) begin
            sb.push_back('{data: want, last: last, acc: cyc, lat: lat});
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
    endtask

    task automatic load_cfg(input logic [CFG_W-1:0] c);
        bit acc;
        int n;
        cfg_valid = 1'b1;
        cfg_bits  = c;
        acc = 0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = cfg_ready;
            @(posedge clk);
            #1;
            n++;
        end
        cfg_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL cfg_timeout: got cfg_ready 0 expected 1");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", NW'(sb.size()), '0);
    endtask

    logic [CFG_W-1:0] c_last, c_b0, c_b24, c_b0_48;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        cfg_valid = 1'b0;
        cfg_bits  = '0;
        c_last = '0;
        for (int i = 48; i < 56; i++) c_last[i] = 1'b1;
        c_b0    = '0; c_b0[0]  = 1'b1;
        c_b24   = '0; c_b24[24] = 1'b1;
        c_b0_48 = '0; c_b0_48[0] = 1'b1; c_b0_48[48] = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {511'b0, out_valid}, '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_last", {511'b0, out_last}, '0);
        check("rst_cfg_ready", {511'b0, cfg_ready}, {511'b0, 1'b1});
        check("rst_in_ready", {511'b0, in_ready}, {511'b0, 1'b1});
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Identity and single-switch routings.
        send(lanes(1), 1'b1, lanes(1), 1'b0);
        drain();
        load_cfg(c_last);
        send(lanes(2), 1'b1, pairs(lanes(2)), 1'b0);
        drain();
        load_cfg(c_b0);
        send(lanes(3), 1'b1, swap2(lanes(3), 0, 1), 1'b0);
        load_cfg(c_b24);
        send(lanes(4), 1'b1, swap2(lanes(4), 0, 8), 1'b0);
        load_cfg(c_b0_48);
        send(lanes(5), 1'b1, lanes(5), 1'b0);
        load_cfg('0);
        drain();

        // Reconfiguration deferred to the frame boundary.
        send(lanes(20), 1'b0, lanes(20), 1'b0);
        load_cfg(c_last);
        check("frame_cfg_ready_a", {511'b0, cfg_ready}, '0);
        send(lanes(21), 1'b0, lanes(21), 1'b0);
        check("frame_cfg_ready_b", {511'b0, cfg_ready}, '0);
        send(lanes(22), 1'b0, lanes(22), 1'b0);
        send(lanes(23), 1'b1, lanes(23), 1'b0);
        check("frame_cfg_ready_c", {511'b0, cfg_ready}, '0);
        send(lanes(24), 1'b0, pairs(lanes(24)), 1'b0);
        check("frame_cfg_ready_d", {511'b0, cfg_ready}, {511'b0, 1'b1});
        send(lanes(25), 1'b1, pairs(lanes(25)), 1'b0);
        drain();

        // Backpressure mid-stream.
        load_cfg('0);
        fork
            begin
                for (int i = 0; i < 10; i++) send(lanes(i), i == 9, lanes(i), 1'b0);
            end
            begin
                repeat (8) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Throughput: 20 back-to-back beats, fixed latency each.
        for (int i = 0; i < 20; i++) send(lanes(40 + i), i == 19, lanes(40 + i), 1'b1);
        drain();

        // Reset mid-frame with a pending config.
        send(lanes(70), 1'b0, lanes(70), 1'b0);
        load_cfg(c_last);
        for (int i = 0; i < 4; i++) send(lanes(71 + i), 1'b0, lanes(71 + i), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        check("mid_rst_out_valid", {511'b0, out_valid}, '0);
        check("mid_rst_cfg_ready", {511'b0, cfg_ready}, {511'b0, 1'b1});
        rst = 1'b0;
        send(lanes(80), 1'b1, lanes(80), 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
